// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, FSM state encoding and the
// rotate-amount wrap helper used by both rotate directions.
package alu_pkg;

   localparam int ALU_WIDTH = 5;
   localparam int ALU_AMT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_DONE   = 2'd2
   } alu_state_e;

   localparam logic [ALU_AMT_W-1:0] AMT_WRAP = ALU_AMT_W'(ALU_WIDTH);

   // 2**AMT_W < 2*WIDTH, so a single conditional subtract is exact.
   function automatic logic [ALU_AMT_W-1:0] amt_mod_width(
      input logic [ALU_AMT_W-1:0] b
   );
      logic [ALU_AMT_W-1:0] m;
      m = b;
      if (b >= AMT_WRAP) begin
         m = b - AMT_WRAP;
      end
      return m;
   endfunction

endpackage

// File: rtl/alu_amt_mod5.sv
// Rotate amount reduced modulo the operand width.
// Same function feeds the ROL path so both directions wrap alike.
module alu_amt_mod5
   import alu_pkg::*;
(
   input  logic [ALU_AMT_W-1:0] b_i,
   output logic [ALU_AMT_W-1:0] m_o
);

   assign m_o = amt_mod_width(b_i);

endmodule

// File: rtl/alu_ror_seq_5bit.sv
// Multi-cycle rotate-right unit: one bit per clock,
// start/ready handshake in, single-cycle done pulse out.
module alu_ror_seq_5bit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int AMT_W = ALU_AMT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [AMT_W-1:0] B,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] R
);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [AMT_W-1:0] amt;

   alu_amt_mod5 u_amt (
      .b_i (B),
      .m_o (amt)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               data_d  = A;
               cnt_d   = amt;
               state_d = (amt == '0) ? ST_DONE : ST_ROTATE;
            end
         end
         ST_ROTATE: begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
            cnt_d  = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Result is captured on the edge that enters DONE.
      if (state_d == ST_DONE) begin
         r_d = data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
      end
   end

   assign ready = (state_q == ST_IDLE);
   assign busy  = (state_q == ST_ROTATE);
   assign done  = (state_q == ST_DONE);
   assign R     = r_q;

endmodule
